div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Sequential signed 32-bit integer divider for the multicycle CPU.
- Produces quotient (LO) and remainder (HI); these feed data inputs of the register write-data multiplexer through the HI/LO registers.
- Started by the control unit with a one-cycle start pulse; reports completion with a one-cycle done pulse.
- Implements MIPS div semantics, including a divide-by-zero exception flag.

Parameters:
- DATA_W, 32, operand/result width; iteration count equals DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- div_start  input  1  start request; sampled only in IDLE.
- dividend  input  DATA_W  signed dividend (rs); sampled on the accepting edge.
- divisor  input  DATA_W  signed divisor (rt); sampled on the accepting edge.
- hi_out  output  DATA_W  remainder.
- lo_out  output  DATA_W  quotient.
- div_busy  output  1  high while the operation is in flight (CALC or FIX).
- div_done  output  1  one-cycle completion pulse.
- div_zero  output  1  divide-by-zero flag, pulsed together with div_done.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high.
  - On a reset edge: state <= IDLE; hi_out = 0, lo_out = 0, div_busy = 0, div_done = 0, div_zero = 0; internal registers are cleared.
  - reset has priority over everything, including mid-operation; the aborted result is discarded.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Start edge E0 = div_start=1 at a rising edge.
  - divisor != 0 at E0:
    - Latch |dividend| and |divisor|.
    - Latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
    - Clear partial remainder; counter <= 0; go to CALC.
  - divisor == 0 at E0: go directly to DONE with div_zero staged; hi_out and lo_out keep their previous values.
- CALC:
  - One restoring step per cycle: shift {rem, quo} left by 1; trial = rem - |divisor|.
  - trial non-negative: rem <= trial, quo[0] <= 1; otherwise quo[0] <= 0.
  - Runs DATA_W cycles (edges E1..E32); after the last step go to FIX.
- FIX (edge E33):
  - lo_out <= sign_q ? -quo : quo.
  - hi_out <= sign_r ? -rem : rem.
  - Go to DONE.
- DONE:
  - div_done = 1 for exactly this one cycle (the cycle after E33); div_zero = 1 in this cycle only on a zero divisor.
  - Always returns to IDLE on the next edge.
- Latency:
  - Normal: E0 → div_done high 33 edges later (34th cycle including the start cycle).
  - Divide by zero: done one cycle after E0.
- div_busy = 1 in CALC and FIX only; 0 in IDLE and DONE.
- Arithmetic:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - All arithmetic is modulo 2^DATA_W.
  - -2^31 / -1 gives lo_out = 0x80000000, hi_out = 0; no overflow flag.
- div_start while not in IDLE is ignored and not queued. Operand changes after E0 have no effect.
- hi_out and lo_out hold their last written values until the next FIX or reset.

Decomposition:
- Shared package div_pkg:
  - State enum {IDLE, CALC, FIX, DONE}.
  - DIV_W = 32.
  - Counter width localparam = clog2(DIV_W) + 1.
- Sub-module div_step (combinational): inputs rem, quo, divisor_abs; outputs next rem and next quo for one restoring iteration. Kept separate so it can be unit-tested.
- Top div_unit holds the FSM, counter, sign latches and output registers.

Test Plan:
- Divide 100 by 7, start pulse → after 33 edges lo_out = 14, hi_out = 2, div_done high one cycle, div_zero = 0, div_busy high for 33 cycles.
- Divide -7 by 2 → lo_out = 0xFFFFFFFD (-3), hi_out = 0xFFFFFFFF (-1); divide 7 by -2 → lo_out = -3, hi_out = 1.
- Divide 0x80000000 by 0xFFFFFFFF → lo_out = 0x80000000, hi_out = 0; divide 5 by 9 → lo_out = 0, hi_out = 5.
- Divide 42 by 0 with prior hi/lo = 2/14 → div_done and div_zero high one cycle after the start edge, hi_out/lo_out stay 2/14, div_busy never asserted.
- Assert div_start again at cycle 10 of a busy operation with different operands → ignored; the original result completes on schedule.
- Assert reset at cycle 15 of an operation → next cycle all outputs 0, state IDLE; a following start with 9 / 3 yields lo_out = 3, hi_out = 0 at normal latency.

Source files
------------

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential signed divider (div_unit) and its
// single restoring-iteration helper (div_step).
//   div_state_t : control FSM states IDLE / CALC / FIX / DONE
//   DIV_W       : operand and result width; also the number of CALC steps
//   CNT_W       : width of the iteration counter
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_W = 32;

    // One extra bit so the counter can hold DIV_W itself without wrapping.
    localparam int CNT_W = $clog2(DIV_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_if.sv
// ---------------------------------------------------------------------------
// div_if
// Request/result bundle between the control unit and the divider.
//   div_start        : one-cycle start request (control unit -> divider)
//   dividend/divisor : signed operands (rs / rt), sampled on the start edge
//   hi_out / lo_out  : remainder / quotient (divider -> HI/LO registers)
//   div_busy         : operation in flight
//   div_done         : one-cycle completion pulse
//   div_zero         : divide-by-zero flag, pulsed with div_done
// The master modport is the control unit side, the slave modport the divider.
// ---------------------------------------------------------------------------
interface div_if
    import div_pkg::*;
    #(parameter int DATA_W = DIV_W)
    ();

    logic              div_start;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;
    logic              div_busy;
    logic              div_done;
    logic              div_zero;

    modport master (
        output div_start,
        output dividend,
        output divisor,
        input  hi_out,
        input  lo_out,
        input  div_busy,
        input  div_done,
        input  div_zero
    );

    modport slave (
        input  div_start,
        input  dividend,
        input  divisor,
        output hi_out,
        output lo_out,
        output div_busy,
        output div_done,
        output div_zero
    );

endinterface

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One iteration of unsigned restoring division, purely combinational.
//   rem         : current partial remainder (always < divisor_abs)
//   quo         : dividend bits still to be consumed / quotient bits produced
//   divisor_abs : magnitude of the divisor
//   rem_next    : partial remainder after this step
//   quo_next    : {quo shifted left, new quotient bit}
// ---------------------------------------------------------------------------
module div_step
    import div_pkg::*;
    #(parameter int DATA_W = DIV_W)
    (
        input  logic [DATA_W-1:0] rem,
        input  logic [DATA_W-1:0] quo,
        input  logic [DATA_W-1:0] divisor_abs,
        output logic [DATA_W-1:0] rem_next,
        output logic [DATA_W-1:0] quo_next
    );

    // The shifted remainder is kept one bit wider than the data path so the
    // comparison against the divisor stays exact even for a divisor
    // magnitude of 2^(DATA_W-1).
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;
    logic            fits;

    // Shift the next dividend bit into the remainder, try subtracting the
    // divisor, and keep the difference only when it did not go negative.
    always_comb begin
        shifted  = {rem, quo[DATA_W-1]};
        trial    = shifted - {1'b0, divisor_abs};
        fits     = (shifted >= {1'b0, divisor_abs});
        rem_next = fits ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_next = {quo[DATA_W-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Sequential signed divider with MIPS div semantics: quotient truncates
// toward zero (lo_out), remainder takes the dividend's sign (hi_out).
// Operands are reduced to magnitudes, divided by DATA_W restoring steps,
// then the signs are restored in a single FIX cycle.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; aborts any operation in flight
//   bus   : div_if slave side (start, operands, hi/lo results, busy,
//           done and divide-by-zero pulses)
// ---------------------------------------------------------------------------
module div_unit
    import div_pkg::*;
    #(parameter int DATA_W = DIV_W)
    (
        input  logic  clk,
        input  logic  reset,
        div_if.slave  bus
    );

    div_state_t        state;
    div_state_t        state_next;

    logic [CNT_W-1:0]  counter;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] divisor_abs;
    logic              sign_q;
    logic              sign_r;
    logic              zero_flag;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;

    logic              busy_c;
    logic              done_c;
    logic              zero_c;

    logic              divisor_is_zero;

    assign divisor_is_zero = (bus.divisor == '0);

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem         (rem),
        .quo         (quo),
        .divisor_abs (divisor_abs),
        .rem_next    (rem_next),
        .quo_next    (quo_next)
    );

    // State register; reset wins over everything, including a running
    // division, whose partial result is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs. A zero divisor skips the iteration
    // entirely and lands in DONE so the flag appears one cycle after start.
    // A start seen outside IDLE is dropped, never queued.
    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        zero_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.div_start) begin
                    state_next = divisor_is_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy_c = 1'b1;
                if (counter == CNT_W'(DATA_W - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy_c     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done_c     = 1'b1;
                zero_c     = zero_flag;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. The start edge captures magnitudes and the two sign bits so
    // later operand changes cannot disturb the running division. The
    // dividend magnitude is loaded into quo, whose top bit is shifted into
    // the remainder each CALC step while quotient bits fill in from below.
    // hi/lo only change in FIX, so a divide-by-zero leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter     <= '0;
            rem         <= '0;
            quo         <= '0;
            divisor_abs <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero_flag   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.div_start) begin
                        zero_flag <= divisor_is_zero;
                        if (!divisor_is_zero) begin
                            quo         <= bus.dividend[DATA_W-1] ? -bus.dividend : bus.dividend;
                            divisor_abs <= bus.divisor[DATA_W-1]  ? -bus.divisor  : bus.divisor;
                            sign_q      <= bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1];
                            sign_r      <= bus.dividend[DATA_W-1];
                            rem         <= '0;
                            counter     <= '0;
                        end
                    end
                end
                CALC: begin
                    rem     <= rem_next;
                    quo     <= quo_next;
                    counter <= counter + 1'b1;
                end
                FIX: begin
                    lo_q <= sign_q ? -quo : quo;
                    hi_q <= sign_r ? -rem : rem;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
    assign bus.div_busy = busy_c;
    assign bus.div_done = done_c;
    assign bus.div_zero = zero_c;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
// Self-checking bench for div_unit. Expected quotient/remainder come from
// 64-bit signed arithmetic (truncating division, remainder with the
// dividend's sign) reduced to 32 bits; expected timing comes from the
// documented latencies.
// ---------------------------------------------------------------------------
module tb_div_unit;
    import div_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    div_if #(.DATA_W(DIV_W)) bus ();

    div_unit #(.DATA_W(DIV_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    // Single comparison point: counts, and reports on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64 bits, then wrapped to 32.
    task automatic refModel(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
    endtask

    // Present one start pulse with operands; returns half a cycle after E0.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.div_start = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        @(negedge clk);
        bus.div_start = 1'b0;
    endtask

    // Full operation: start, wait (bounded) for done, check results/timing.
    // interfere_at >= 0 injects a second start pulse with new operands.
    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int interfere_at);
        logic [31:0] q;
        logic [31:0] r;
        logic        zero_exp;
        int          cycles;
        int          busy_cnt;
        zero_exp = (b == 32'd0);
        if (zero_exp) begin
            q = exp_lo;
            r = exp_hi;
        end else begin
            refModel(a, b, q, r);
        end
        applyStimulus(a, b);
        cycles   = 0;
        busy_cnt = 0;
        while (bus.div_done !== 1'b1 && cycles < 200) begin
            if (bus.div_busy === 1'b1) busy_cnt++;
            if (cycles == interfere_at) begin
                bus.div_start = 1'b1;
                bus.dividend  = $urandom;
                bus.divisor   = $urandom | 32'd1;
            end else begin
                bus.div_start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        bus.div_start = 1'b0;
        checkOutput({tag, " latency"}, 32'(cycles), zero_exp ? 32'd0 : 32'd33);
        checkOutput({tag, " busy_cycles"}, 32'(busy_cnt), zero_exp ? 32'd0 : 32'd33);
        checkOutput({tag, " lo"}, bus.lo_out, q);
        checkOutput({tag, " hi"}, bus.hi_out, r);
        checkOutput({tag, " zero"}, 32'(bus.div_zero), 32'(zero_exp));
        exp_lo = q;
        exp_hi = r;
        @(negedge clk);
        checkOutput({tag, " done_pulse_width"}, 32'(bus.div_done), 32'd0);
        checkOutput({tag, " zero_after"}, 32'(bus.div_zero), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;

        reset         = 1'b1;
        bus.div_start = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        exp_hi        = '0;
        exp_lo        = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset lo",   bus.lo_out, 32'd0);
        checkOutput("reset hi",   bus.hi_out, 32'd0);
        checkOutput("reset busy", 32'(bus.div_busy), 32'd0);
        checkOutput("reset done", 32'(bus.div_done), 32'd0);
        checkOutput("reset zero", 32'(bus.div_zero), 32'd0);
        reset = 1'b0;

        runOp("100/7",   32'd100, 32'd7, -1);
        runOp("42/0",    32'd42,  32'd0, -1);
        runOp("-7/2",    32'hFFFF_FFF9, 32'd2, -1);
        runOp("7/-2",    32'd7, 32'hFFFF_FFFE, -1);
        runOp("min/-1",  32'h8000_0000, 32'hFFFF_FFFF, -1);
        runOp("5/9",     32'd5, 32'd9, -1);
        runOp("min/1",   32'h8000_0000, 32'd1, -1);
        runOp("-9/min",  32'hFFFF_FFF7, 32'h8000_0000, -1);
        runOp("ignored_start", 32'd1000, 32'd7, 10);

        // Reset in the middle of a division: result must be discarded.
        applyStimulus(32'd12345, 32'd67);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset lo",   bus.lo_out, 32'd0);
        checkOutput("midreset hi",   bus.hi_out, 32'd0);
        checkOutput("midreset busy", 32'(bus.div_busy), 32'd0);
        checkOutput("midreset done", 32'(bus.div_done), 32'd0);
        checkOutput("midreset zero", 32'(bus.div_zero), 32'd0);
        exp_hi = '0;
        exp_lo = '0;
        runOp("9/3", 32'd9, 32'd3, -1);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                default: b = (i % 8 == 3) ? 32'd0 : ($urandom & 32'h0000_FFFF);
            endcase
            if (i % 6 == 5) a = 32'h8000_0000;
            runOp($sformatf("rand%0d", i), a, b, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
